// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-select and state encodings for the control unit slice.
package control_pkg;

    localparam int OP_WIDTH    = 2;
    localparam int INSTR_WIDTH = 8;
    localparam int IMM_WIDTH   = 5;

    typedef enum logic [2:0] {
        OPC_NOP  = 3'b000,
        OPC_LDI  = 3'b001,
        OPC_ADDI = 3'b010,
        OPC_INC  = 3'b011,
        OPC_JMP  = 3'b100,
        OPC_JZ   = 3'b101,
        OPC_RSVD = 3'b110,
        OPC_HALT = 3'b111
    } opcode_e;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_SUM   = 2'b00,
        ALU_PASS0 = 2'b01,
        ALU_INC0  = 2'b10,
        ALU_PASS1 = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    writes_acc;
        logic    is_jump;
        logic    is_cond;
        logic    is_halt;
    } decode_t;

endpackage

// File: rtl/control_unit_if.sv
// Fetch handshake and ALU operand/result bundle between the sequencer and its neighbours.
interface control_unit_if import control_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                   INSTR_REQ;
    logic [ADDR_WIDTH-1:0]  INSTR_ADDR;
    logic                   INSTR_VALID;
    logic [INSTR_WIDTH-1:0] INSTR_DATA;
    logic [OP_WIDTH-1:0]    ALU_OP;
    logic [DATA_WIDTH-1:0]  ALU_IN0;
    logic [DATA_WIDTH-1:0]  ALU_IN1;
    logic [DATA_WIDTH-1:0]  ALU_OUT;

    modport master (
        output INSTR_REQ, INSTR_ADDR, ALU_OP, ALU_IN0, ALU_IN1,
        input  INSTR_VALID, INSTR_DATA, ALU_OUT
    );

    modport slave (
        input  INSTR_REQ, INSTR_ADDR, ALU_OP, ALU_IN0, ALU_IN1,
        output INSTR_VALID, INSTR_DATA, ALU_OUT
    );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational opcode decode: ALU select plus the control flags the sequencer acts on.
module control_decode import control_pkg::*; (
    input  opcode_e opc_i,
    output decode_t dec_o
);

    always_comb begin
        dec_o.alu_op     = ALU_PASS0;
        dec_o.writes_acc = 1'b0;
        dec_o.is_jump    = 1'b0;
        dec_o.is_cond    = 1'b0;
        dec_o.is_halt    = 1'b0;
        case (opc_i)
            OPC_LDI: begin
                dec_o.alu_op     = ALU_PASS1;
                dec_o.writes_acc = 1'b1;
            end
            OPC_ADDI: begin
                dec_o.alu_op     = ALU_SUM;
                dec_o.writes_acc = 1'b1;
            end
            OPC_INC: begin
                dec_o.alu_op     = ALU_INC0;
                dec_o.writes_acc = 1'b1;
            end
            OPC_JMP: dec_o.is_jump = 1'b1;
            OPC_JZ: begin
                dec_o.is_jump = 1'b1;
                dec_o.is_cond = 1'b1;
            end
            OPC_HALT: dec_o.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches words from program memory and drives an external combinational ALU.
module control_unit import control_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    control_unit_if.master        bus,
    output logic [DATA_WIDTH-1:0] ACC,
    output logic                  ZERO,
    output logic                  HALTED
);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  pc_d;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic                   z_q;
    logic                   req_q;
    logic                   halted_q;

    decode_t                dec;
    logic [IMM_WIDTH-1:0]   imm;
    logic                   inExec;
    logic                   takeJump;

    control_decode u_decode (
        .opc_i (opcode_e'(ir_q[INSTR_WIDTH-1:IMM_WIDTH])),
        .dec_o (dec)
    );

    assign imm      = ir_q[IMM_WIDTH-1:0];
    assign inExec   = (state_q == EXEC);
    assign takeJump = dec.is_jump && (!dec.is_cond || z_q);

    // Program counter has its own incrementer so the ALU only ever sees accumulator work.
    always_comb begin
        pc_d = pc_q + ADDR_WIDTH'(1);
        if (dec.is_halt)
            pc_d = pc_q;
        else if (takeJump)
            pc_d = ADDR_WIDTH'(imm);
    end

    assign bus.INSTR_REQ  = req_q;
    assign bus.INSTR_ADDR = pc_q;
    assign bus.ALU_OP     = inExec ? dec.alu_op : ALU_PASS0;
    assign bus.ALU_IN0    = acc_q;
    assign bus.ALU_IN1    = inExec ? DATA_WIDTH'(imm) : '0;

    assign ACC    = acc_q;
    assign ZERO   = z_q;
    assign HALTED = halted_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            acc_q    <= '0;
            z_q      <= 1'b0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.INSTR_VALID) begin
                        ir_q    <= bus.INSTR_DATA;
                        req_q   <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    pc_q <= pc_d;
                    if (dec.writes_acc) begin
                        acc_q <= bus.ALU_OUT;
                        z_q   <= (bus.ALU_OUT == '0);
                    end
                    if (dec.is_halt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                HALT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: a program-level reference model predicts every fetch and the final machine state.
module tb_control_unit;
    import control_pkg::*;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] acc;
        logic       z;
    } fetchExp_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic [7:0] ACC;
    logic       ZERO;
    logic       HALTED;

    control_unit_if bus ();

    control_unit dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .bus    (bus),
        .ACC    (ACC),
        .ZERO   (ZERO),
        .HALTED (HALTED)
    );

    always #5 CLK = ~CLK;

    fetchExp_t  expQ[$];
    logic [7:0] mem [256];
    int         testsRun    = 0;
    int         testsFailed = 0;
    int         memDelayMin = 0;
    int         memDelayMax = 0;
    int         stallAddr   = -1;
    bit         spuriousValid = 1'b0;
    logic [7:0] expAcc;
    logic [7:0] expHaltPc;
    logic       expZ;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The ALU that the parent would normally instantiate.
    always_comb begin
        bus.ALU_OUT = '0;
        case (bus.ALU_OP)
            ALU_SUM:   bus.ALU_OUT = bus.ALU_IN0 + bus.ALU_IN1;
            ALU_PASS0: bus.ALU_OUT = bus.ALU_IN0;
            ALU_INC0:  bus.ALU_OUT = bus.ALU_IN0 + 8'd1;
            ALU_PASS1: bus.ALU_OUT = bus.ALU_IN1;
            default:   bus.ALU_OUT = '0;
        endcase
    end

    // Program memory responder with a per-request random latency.
    initial begin
        int  waitCnt;
        int  delay;
        bit  waiting;
        waitCnt = 0;
        delay   = 0;
        waiting = 1'b0;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR_DATA  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (spuriousValid) begin
                bus.INSTR_VALID = 1'($urandom_range(0, 1));
                bus.INSTR_DATA  = 8'($urandom);
            end else if (bus.INSTR_VALID) begin
                bus.INSTR_VALID = 1'b0;
            end else if (!bus.INSTR_REQ) begin
                waiting = 1'b0;
            end else if (int'(bus.INSTR_ADDR) != stallAddr) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    waitCnt = 0;
                    delay   = $urandom_range(memDelayMin, memDelayMax);
                end
                if (waitCnt >= delay) begin
                    bus.INSTR_VALID = 1'b1;
                    bus.INSTR_DATA  = mem[bus.INSTR_ADDR];
                    waiting = 1'b0;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Monitor: every handshake pops one predicted fetch; wait cycles must hold the request steady.
    initial begin
        fetchExp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && bus.INSTR_REQ) begin
                if (bus.INSTR_VALID) begin
                    checkOutput("fetchExpected", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("fetchAddr", 32'(bus.INSTR_ADDR), 32'(e.addr));
                        checkOutput("fetchAcc", 32'(ACC), 32'(e.acc));
                        checkOutput("fetchZero", 32'(ZERO), 32'(e.z));
                    end
                end else if (expQ.size() > 0) begin
                    checkOutput("waitAddr", 32'(bus.INSTR_ADDR), 32'(expQ[0].addr));
                    checkOutput("waitAcc", 32'(ACC), 32'(expQ[0].acc));
                    checkOutput("waitAluOp", 32'(bus.ALU_OP), 32'(ALU_PASS0));
                    checkOutput("waitIn1", 32'(bus.ALU_IN1), 32'd0);
                end
            end
        end
    end

    // Reference model: runs the loaded program instruction by instruction.
    task automatic runModel();
        int pc    = 0;
        int acc   = 0;
        int imm;
        int steps = 0;
        bit z     = 1'b0;
        bit done  = 1'b0;
        logic [7:0] instr;
        expQ.delete();
        while (!done && steps < 2000) begin
            expQ.push_back('{addr: 8'(pc), acc: 8'(acc), z: z});
            instr = mem[pc];
            imm   = int'(instr[4:0]);
            case (instr[7:5])
                3'd1: begin acc = imm; z = (acc == 0); pc = (pc + 1) % 256; end
                3'd2: begin acc = (acc + imm) % 256; z = (acc == 0); pc = (pc + 1) % 256; end
                3'd3: begin acc = (acc + 1) % 256; z = (acc == 0); pc = (pc + 1) % 256; end
                3'd4: pc = imm;
                3'd5: pc = z ? imm : (pc + 1) % 256;
                3'd7: done = 1'b1;
                default: pc = (pc + 1) % 256;
            endcase
            steps++;
        end
        expAcc    = 8'(acc);
        expZ      = z;
        expHaltPc = 8'(pc);
    endtask

    task automatic applyReset();
        RST_N = 1'b0;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("resetAcc", 32'(ACC), 32'd0);
        checkOutput("resetZero", 32'(ZERO), 32'd0);
        checkOutput("resetHalted", 32'(HALTED), 32'd0);
        checkOutput("resetReq", 32'(bus.INSTR_REQ), 32'd0);
        checkOutput("resetAddr", 32'(bus.INSTR_ADDR), 32'd0);
        checkOutput("resetAluOp", 32'(bus.ALU_OP), 32'(ALU_PASS0));
        RST_N = 1'b1;
    endtask

    task automatic startPulse();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input int dMin, input int dMax, input int expCycles);
        int cycles;
        memDelayMin   = dMin;
        memDelayMax   = dMax;
        stallAddr     = -1;
        spuriousValid = 1'b0;
        applyReset();
        runModel();
        startPulse();
        cycles = 0;
        while (!HALTED && cycles < 4000) begin
            @(negedge CLK);
            cycles++;
            if (expCycles == 0) START = 1'($urandom_range(0, 1));
        end
        START = 1'b0;
        checkOutput({name, ":halted"}, 32'(HALTED), 32'd1);
        checkOutput({name, ":acc"}, 32'(ACC), 32'(expAcc));
        checkOutput({name, ":zero"}, 32'(ZERO), 32'(expZ));
        checkOutput({name, ":haltPc"}, 32'(bus.INSTR_ADDR), 32'(expHaltPc));
        checkOutput({name, ":reqLow"}, 32'(bus.INSTR_REQ), 32'd0);
        checkOutput({name, ":drained"}, 32'(expQ.size()), 32'd0);
        if (expCycles > 0) checkOutput({name, ":cycles"}, 32'(cycles), 32'(expCycles));
    endtask

    task automatic clearMem();
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    endtask

    task automatic loadBasic(input logic [7:0] lastAdd);
        clearMem();
        mem[0] = 8'h25;
        mem[1] = 8'h43;
        mem[2] = 8'h60;
        mem[3] = lastAdd;
        mem[4] = 8'hE0;
    endtask

    // Random programs only jump forward and end in HALT at 31, so they always terminate.
    task automatic loadRandomProgram();
        int opc;
        int imm;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 31; a++) begin
            opc = $urandom_range(0, 7);
            imm = $urandom_range(0, 31);
            if (opc == 4 || opc == 5) imm = $urandom_range(a + 1, 31);
            if (opc == 7 && $urandom_range(0, 3) != 0) opc = 2;
            mem[a] = {3'(opc), 5'(imm)};
        end
        mem[31] = 8'hE0;
    endtask

    initial begin
        int cycles;
        RST_N = 1'b0;
        START = 1'b0;

        loadBasic(8'hE0);
        applyStimulus("basic", 0, 0, 8);

        spuriousValid = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            START = 1'($urandom_range(0, 1));
            checkOutput("haltReq", 32'(bus.INSTR_REQ), 32'd0);
            checkOutput("haltHalted", 32'(HALTED), 32'd1);
            checkOutput("haltAcc", 32'(ACC), 32'(expAcc));
            checkOutput("haltAddr", 32'(bus.INSTR_ADDR), 32'(expHaltPc));
            checkOutput("haltAluOp", 32'(bus.ALU_OP), 32'(ALU_PASS0));
        end
        spuriousValid = 1'b0;
        START = 1'b0;

        loadBasic(8'hE0);
        applyStimulus("delay3", 3, 3, 0);

        clearMem();
        mem[0] = 8'h3F;
        for (int a = 1; a <= 7; a++) mem[a] = 8'h5F;
        mem[8]  = 8'h47;
        mem[9]  = 8'h60;
        mem[10] = 8'hB4;
        mem[11] = 8'hE0;
        mem[20] = 8'hE0;
        applyStimulus("jzTaken", 0, 1, 0);
        mem[9] = 8'h00;
        applyStimulus("jzNotTaken", 0, 1, 0);

        clearMem();
        mem[0]   = 8'hBF;
        mem[1]   = 8'h83;
        mem[2]   = 8'hE0;
        mem[31]  = 8'hA2;
        mem[253] = 8'h20;
        applyStimulus("pcWrap", 0, 1, 0);

        // Reset while the ADDI fetch at address 3 is stalled.
        loadBasic(8'h42);
        memDelayMin = 0;
        memDelayMax = 0;
        stallAddr   = 3;
        applyReset();
        runModel();
        startPulse();
        cycles = 0;
        while (!(bus.INSTR_REQ && bus.INSTR_ADDR == 8'd3) && cycles < 100) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput("rstReachedFetch", 32'(bus.INSTR_REQ && bus.INSTR_ADDR == 8'd3), 32'd1);
        checkOutput("rstAccBefore", 32'(ACC), 32'd9);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("rstAcc", 32'(ACC), 32'd0);
        checkOutput("rstAddr", 32'(bus.INSTR_ADDR), 32'd0);
        checkOutput("rstReq", 32'(bus.INSTR_REQ), 32'd0);
        checkOutput("rstHalted", 32'(HALTED), 32'd0);
        expQ.delete();
        stallAddr = -1;
        @(negedge CLK);
        RST_N = 1'b1;
        applyStimulus("afterReset", 0, 0, 10);

        for (int i = 0; i < 8; i++) begin
            loadRandomProgram();
            applyStimulus($sformatf("random%0d", i), 0, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
